seek_step_monitor: RTL and testbench

//   Watches the ST-506 STEP/DIR/SEEK_COMPLETE/TRACK0 lines (already synchronised to clk),

---
 rtl/seek_step_monitor.sv | 164 ++++++++++++++++
 tb/tb_seek_step_monitor.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seek_step_monitor.sv
// ST-506 seek monitor: groups STEP pulses into seeks, tracks the head cylinder and pulses
// seek_start/seek_complete/seek_error. Define SEEK_TRACK0_CHECK_EN for TRACK0 cross-check and resync.
module seek_step_monitor #(
  parameter int unsigned STEP_GAP_CLKS     = 90000,
  parameter int unsigned SEEK_TIMEOUT_CLKS = 300000000,
  parameter int unsigned MAX_CYL           = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic        dir,
  input  logic        drive_seek_complete,
  input  logic        track0,
  output logic        seek_start,
  output logic        seek_complete,
  output logic        seek_error,
  output logic [15:0] seek_distance,
  output logic [15:0] current_cylinder,
  output logic        seek_busy
);

  localparam int GAP_W = $clog2(STEP_GAP_CLKS + 1);
  localparam int TMO_W = $clog2(SEEK_TIMEOUT_CLKS + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STEP_GAP_CLKS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SEEK_TIMEOUT_CLKS - 1);
  localparam logic [15:0] CYL_TOP = 16'(MAX_CYL);
  localparam logic signed [16:0] NET_MAX = 17'sd65535;
  localparam logic signed [16:0] NET_MIN = -17'sd65535;

  typedef enum logic [1:0] {IDLE, STEPPING, SETTLE} state_t;

  state_t state, state_n;
  logic step_d, step_edge;
  logic moved;
  logic [15:0] base_cyl, stepped_cyl, cyl_n, dist_n;
  logic signed [16:0] net, net_n, net_fresh, net_acc;
  logic [16:0] abs_net;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic busy_n, start_n, complete_n, error_n;

  assign step_edge = step & ~step_d;

  // Effect of a step on this cycle: blocked steps leave both cylinder and net untouched.
  always_comb begin
    base_cyl = current_cylinder;
`ifdef SEEK_TRACK0_CHECK_EN
    if (state == IDLE && track0) base_cyl = '0;
`endif
    moved = 1'b0;
    stepped_cyl = base_cyl;
    if (dir) begin
      if (base_cyl < CYL_TOP) begin
        moved = 1'b1;
        stepped_cyl = base_cyl + 16'd1;
      end
    end else if (base_cyl != 16'd0 && !track0) begin
      moved = 1'b1;
      stepped_cyl = base_cyl - 16'd1;
    end
    net_fresh = !moved ? 17'sd0 : (dir ? 17'sd1 : -17'sd1);
    net_acc = net;
    if (moved) begin
      if (dir && net != NET_MAX) net_acc = net + 17'sd1;
      else if (!dir && net != NET_MIN) net_acc = net - 17'sd1;
    end
    abs_net = net[16] ? 17'(-net) : 17'(net);
  end

  always_comb begin
    state_n    = state;
    busy_n     = seek_busy;
    net_n      = net;
    cyl_n      = current_cylinder;
    gap_n      = gap_cnt;
    tmo_n      = tmo_cnt;
    dist_n     = seek_distance;
    start_n    = 1'b0;
    complete_n = 1'b0;
    error_n    = 1'b0;
    case (state)
      IDLE: begin
        cyl_n = base_cyl;
        if (step_edge) begin
          state_n = STEPPING;
          busy_n  = 1'b1;
          net_n   = net_fresh;
          cyl_n   = stepped_cyl;
          gap_n   = '0;
        end
      end
      STEPPING: begin
        if (step_edge) begin
          net_n = net_acc;
          cyl_n = stepped_cyl;
          gap_n = '0;
        end else if (gap_cnt == GAP_LAST) begin
          state_n = SETTLE;
          start_n = 1'b1;
          dist_n  = abs_net[16] ? 16'hFFFF : abs_net[15:0];
          tmo_n   = '0;
        end else begin
          gap_n = gap_cnt + GAP_W'(1);
        end
      end
      SETTLE: begin
        // A new step wins over a same-cycle ready so no step is ever lost.
        if (step_edge) begin
          error_n = 1'b1;
          state_n = STEPPING;
          net_n   = net_fresh;
          cyl_n   = stepped_cyl;
          gap_n   = '0;
        end else if (drive_seek_complete) begin
          state_n = IDLE;
          busy_n  = 1'b0;
`ifdef SEEK_TRACK0_CHECK_EN
          if ((current_cylinder == 16'd0) != track0) error_n = 1'b1;
          else complete_n = 1'b1;
          if (track0) cyl_n = '0;
`else
          complete_n = 1'b1;
`endif
        end else if (tmo_cnt == TMO_LAST) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          error_n = 1'b1;
        end else begin
          tmo_n = tmo_cnt + TMO_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      step_d           <= 1'b0;
      net              <= '0;
      gap_cnt          <= '0;
      tmo_cnt          <= '0;
      seek_busy        <= 1'b0;
      seek_start       <= 1'b0;
      seek_complete    <= 1'b0;
      seek_error       <= 1'b0;
      seek_distance    <= '0;
      current_cylinder <= '0;
    end else begin
      state            <= state_n;
      step_d           <= step;
      net              <= net_n;
      gap_cnt          <= gap_n;
      tmo_cnt          <= tmo_n;
      seek_busy        <= busy_n;
      seek_start       <= start_n;
      seek_complete    <= complete_n;
      seek_error       <= error_n;
      seek_distance    <= dist_n;
      current_cylinder <= cyl_n;
    end
  end

endmodule

// File: tb/tb_seek_step_monitor.sv
// Bench for seek_step_monitor: directed seeks with literal timing/distance expectations,
// then randomized step bursts compared every cycle against a seek-level model.
module tb_seek_step_monitor;

  localparam int GAP     = 20;
  localparam int TIMEOUT = 150;
  localparam int MAX_CYL = 12;

  logic clk, reset, step, dir, drive_seek_complete, track0;
  logic seek_start, seek_complete, seek_error, seek_busy;
  logic [15:0] seek_distance, current_cylinder;

  int errors = 0;
  int checks = 0;
  int n_start = 0, n_complete = 0, n_error = 0;
  int last_dist = 0;
  int t0_mode = 0;
  bit model_valid = 0;

  // Model: phase 0 = no seek, 1 = burst open, 2 = waiting for drive ready
  int cyc = 0, phase = 0, m_cyl = 0, m_net = 0, last_edge = 0, close_cyc = 0, m_abs = 0;
  bit m_prev_step = 0, m_edge = 0;
  logic e_start = 0, e_complete = 0, e_error = 0, e_busy = 0;
  int e_dist = 0;

  seek_step_monitor #(
    .STEP_GAP_CLKS(GAP),
    .SEEK_TIMEOUT_CLKS(TIMEOUT),
    .MAX_CYL(MAX_CYL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .step(step),
    .dir(dir),
    .drive_seek_complete(drive_seek_complete),
    .track0(track0),
    .seek_start(seek_start),
    .seek_complete(seek_complete),
    .seek_error(seek_error),
    .seek_distance(seek_distance),
    .current_cylinder(current_cylinder),
    .seek_busy(seek_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic d, input logic r);
    step = s;
    dir = d;
    drive_seek_complete = r;
    track0 = (t0_mode == 0) ? (m_cyl == 0) : (t0_mode == 2);
    @(negedge clk);
    #1;
  endtask

  task automatic doStep(input logic d, input int lo);
    applyStimulus(1'b1, d, 1'b0);
    applyStimulus(1'b1, d, 1'b0);
    repeat (lo) applyStimulus(1'b0, d, 1'b0);
  endtask

  function automatic int eventCount(input int kind);
    if (kind == 0) return n_start;
    if (kind == 1) return n_complete;
    return n_error;
  endfunction

  task automatic waitEvent(input int kind, input logic r, input int limit, output int k);
    int base;
    base = eventCount(kind);
    k = 0;
    while (eventCount(kind) == base && k < limit) begin
      applyStimulus(1'b0, 1'b0, r);
      k++;
    end
    if (eventCount(kind) == base) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_event kind %0d: no event within %0d cycles, expected one", kind, limit);
    end
  endtask

  // Seek-level reference: a burst closes GAP idle cycles after its last step edge, and the
  // drive then has TIMEOUT cycles to report ready; every result is visible one cycle later.
  task automatic modelStep();
    cyc++;
    if (reset) begin
      m_prev_step = 0; phase = 0; m_cyl = 0; m_net = 0;
      e_start = 0; e_complete = 0; e_error = 0; e_busy = 0; e_dist = 0;
      model_valid = 1;
    end else begin
      m_edge = step && !m_prev_step;
      m_prev_step = step;
      e_start = 0; e_complete = 0; e_error = 0;
`ifdef SEEK_TRACK0_CHECK_EN
      if (phase == 0 && track0) m_cyl = 0;
`endif
      if (m_edge) begin
        if (phase == 2) e_error = 1;
        if (phase != 1) m_net = 0;
        if (dir && m_cyl < MAX_CYL) begin m_cyl++; m_net++; end
        else if (!dir && m_cyl > 0 && !track0) begin m_cyl--; m_net--; end
        phase = 1; last_edge = cyc; e_busy = 1;
      end else if (phase == 1 && cyc - last_edge == GAP) begin
        phase = 2; close_cyc = cyc; e_start = 1;
        m_abs = (m_net < 0) ? -m_net : m_net;
        e_dist = (m_abs > 65535) ? 65535 : m_abs;
      end else if (phase == 2 && drive_seek_complete) begin
        phase = 0; e_busy = 0;
`ifdef SEEK_TRACK0_CHECK_EN
        if ((m_cyl == 0) != track0) e_error = 1;
        else e_complete = 1;
        if (track0) m_cyl = 0;
`else
        e_complete = 1;
`endif
      end else if (phase == 2 && cyc - close_cyc == TIMEOUT) begin
        phase = 0; e_busy = 0; e_error = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      checkOutput("seek_start", seek_start, e_start);
      checkOutput("seek_complete", seek_complete, e_complete);
      checkOutput("seek_error", seek_error, e_error);
      checkOutput("seek_busy", seek_busy, e_busy);
      checkOutput("seek_distance", seek_distance, e_dist);
      checkOutput("current_cylinder", current_cylinder, m_cyl);
      if (seek_start === 1'b1) begin n_start++; last_dist = seek_distance; end
      if (seek_complete === 1'b1) n_complete++;
      if (seek_error === 1'b1) n_error++;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k, kw, s0, c0, e0, nsteps, lo, w;
    logic rd;
    reset = 1'b1; step = 1'b0; dir = 1'b0; drive_seek_complete = 1'b0; track0 = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset_busy", seek_busy, 0);
    checkOutput("reset_cylinder", current_cylinder, 0);
    checkOutput("reset_distance", seek_distance, 0);
    reset = 1'b0;

    $display("[TB] five inward steps from cylinder 0");
    s0 = n_start;
    repeat (4) doStep(1'b1, 8);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEvent(0, 1'b0, 100, kw);
    k = 2 + kw;
    checkOutput("t1_gap_latency", k, GAP + 1);
    checkOutput("t1_distance", last_dist, 5);
    checkOutput("t1_busy", seek_busy, 1);
    repeat (30) applyStimulus(1'b0, 1'b0, 1'b0);
    waitEvent(1, 1'b1, 5, kw);
    checkOutput("t1_complete_latency", kw, 1);
    checkOutput("t1_cylinder", current_cylinder, 5);
    checkOutput("t1_busy_clear", seek_busy, 0);
    checkOutput("t1_starts", n_start - s0, 1);

    $display("[TB] outward to cylinder 3, then ten outward steps into track 0");
    doStep(1'b0, 8);
    doStep(1'b0, 8);
    waitEvent(0, 1'b0, 100, kw);
    waitEvent(1, 1'b1, 5, kw);
    checkOutput("t2_start_cylinder", current_cylinder, 3);
    repeat (10) doStep(1'b0, 6);
    waitEvent(0, 1'b0, 100, kw);
    checkOutput("t2_distance", last_dist, 3);
    waitEvent(1, 1'b1, 5, kw);
    checkOutput("t2_cylinder", current_cylinder, 0);

    $display("[TB] three in, three out: zero net movement");
    c0 = n_complete;
    repeat (3) doStep(1'b1, 6);
    repeat (3) doStep(1'b0, 6);
    waitEvent(0, 1'b0, 100, kw);
    checkOutput("t4_distance", last_dist, 0);
    waitEvent(1, 1'b1, 5, kw);
    checkOutput("t4_completes", n_complete - c0, 1);
    checkOutput("t4_cylinder", current_cylinder, 0);

    $display("[TB] step during settle");
    s0 = n_start; c0 = n_complete; e0 = n_error;
    repeat (2) doStep(1'b1, 6);
    waitEvent(0, 1'b0, 100, kw);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
    doStep(1'b1, 6);
    checkOutput("t5_error", n_error - e0, 1);
    checkOutput("t5_busy", seek_busy, 1);
    doStep(1'b1, 6);
    waitEvent(0, 1'b0, 100, kw);
    checkOutput("t5_distance", last_dist, 2);
    waitEvent(1, 1'b1, 5, kw);
    checkOutput("t5_starts", n_start - s0, 2);
    checkOutput("t5_completes", n_complete - c0, 1);
    checkOutput("t5_cylinder", current_cylinder, 4);

`ifdef SEEK_TRACK0_CHECK_EN
    $display("[TB] arrive at tracked cylinder 0 with track0 low");
    c0 = n_complete;
    t0_mode = 1;
    repeat (4) doStep(1'b0, 6);
    waitEvent(0, 1'b0, 100, kw);
    checkOutput("t0chk_distance", last_dist, 4);
    waitEvent(2, 1'b1, 5, kw);
    checkOutput("t0chk_error_latency", kw, 1);
    checkOutput("t0chk_no_complete", n_complete - c0, 0);
    t0_mode = 0;
`endif

    $display("[TB] drive never ready: timeout");
    c0 = n_complete; e0 = n_error;
    repeat (4) doStep(1'b1, 6);
    waitEvent(0, 1'b0, 100, kw);
    waitEvent(2, 1'b0, TIMEOUT + 20, kw);
    checkOutput("t3_timeout_latency", kw, TIMEOUT);
    checkOutput("t3_busy", seek_busy, 0);
    checkOutput("t3_no_complete", n_complete - c0, 0);
    checkOutput("t3_errors", n_error - e0, 1);

    $display("[TB] reset in the middle of a burst");
    s0 = n_start; c0 = n_complete; e0 = n_error;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rst_busy_before", seek_busy, 1);
    reset = 1'b1;
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_busy", seek_busy, 0);
    checkOutput("rst_cylinder", current_cylinder, 0);
    checkOutput("rst_distance", seek_distance, 0);
    reset = 1'b0;
    repeat (GAP + 10) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_no_pulses", (n_start - s0) + (n_complete - c0) + (n_error - e0), 0);

    $display("[TB] randomized bursts");
    for (int ep = 0; ep < 40; ep++) begin
      t0_mode = ($urandom_range(0, 19) == 0) ? 2 : (($urandom_range(0, 19) == 0) ? 1 : 0);
      nsteps = $urandom_range(1, 6);
      for (int s = 0; s < nsteps; s++) begin
        rd = ($urandom_range(0, 3) != 0);
        if (m_cyl > MAX_CYL / 2) rd = !rd;
        repeat ($urandom_range(1, 3)) applyStimulus(1'b1, rd, $urandom_range(0, 15) == 0);
        lo = $urandom_range(1, GAP + 6);
        repeat (lo) applyStimulus(1'b0, rd, $urandom_range(0, 15) == 0);
      end
      w = $urandom_range(0, TIMEOUT + 30);
      repeat (w) applyStimulus(1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 1'b0, 1'b1);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
      end
    end
    t0_mode = 0;
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
